rf_sequencer: RTL and testbench
===============================

Name: rf_sequencer

Overview:
- Multi-cycle initiator for the 4-register file: takes 8-bit instructions over a valid/ready handshake and drives SEL_A/SEL_B reads.
- Captures OUT_A/OUT_B, computes an ALU result, then drives SEL_W/DATA_IN/write_en to write the result back.
- Sits between the instruction source (fetch/bench) and reg_file; the register file's only write master.

Parameters:
- WIDTH, 4, data width of registers, ALU and DATA_IN.
- ADDR_W, 2, register select width (2^ADDR_W registers).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  sequencer can accept.
- instr  input  8  [7:6] op, [5:4] rd, [3:2] ra, [1:0] rb.
- SEL_A  output  ADDR_W  reg file read port A select.
- SEL_B  output  ADDR_W  reg file read port B select.
- SEL_W  output  ADDR_W  reg file write select.
- write_en  output  1  reg file write enable.
- DATA_IN  output  WIDTH  write data.
- OUT_A  input  WIDTH  reg file read data A (combinational from SEL_A).
- OUT_B  input  WIDTH  reg file read data B.
- carry  output  1  carry/borrow flag of last executed op.
- zero  output  1  result==0 flag of last executed op.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse, high during the WRITE cycle.

Behaviour:
- Ops:
  - 00 ADD: rd = ra+rb; carry = bit WIDTH of the WIDTH+1-bit sum.
  - 01 SUB: rd = ra-rb mod 2^WIDTH; carry = borrow (ra<rb, unsigned).
  - 10 AND: rd = ra&rb; carry=0.
  - 11 LDI: rd = {ra,rb} as a 4-bit immediate; carry=0; register reads are ignored.
  - zero = (result==0) for all ops.
- FSM states IDLE, READ, EXEC, WRITE.
  - IDLE: instr_ready=1; on instr_valid&instr_ready latch instr, go to READ.
  - READ: SEL_A=ra, SEL_B=rb; capture OUT_A/OUT_B into operand registers at the clock edge; go to EXEC.
  - EXEC: compute result into a result register; update carry/zero at the edge; go to WRITE.
  - WRITE: SEL_W=rd, DATA_IN=result, write_en=1, done=1; the write commits at the closing edge; go to IDLE.
- Latency: acceptance edge to write commit is 3 cycles. Throughput is one instruction per 4 cycles.
- write_en is high only in WRITE and is combinationally gated by ~reset, so an asserted reset suppresses a write on that edge.
- SEL_A/SEL_B/SEL_W hold their last values outside their active states. DATA_IN holds the result register.
- Reset values: state=IDLE, SEL_A=SEL_B=SEL_W=0, DATA_IN=0, write_en=0, carry=0, zero=0, done=0, busy=0, instr_ready=1 from the cycle after reset deasserts.
- Reset mid-operation: the instruction is abandoned, no write occurs, and flags clear.
- instr_valid while busy (without the optional feature): ignored. The source must hold instr stable until it is accepted.
- rd==ra or rd==rb: legal. Operands are captured in READ, before the write.

Optional Feature:
- Macro: RF_SEQ_OVERLAP_EN.
- Defined: instr_ready=1 in IDLE and in WRITE. Acceptance in WRITE goes directly to READ, giving back-to-back throughput of one instruction per 3 cycles. The next READ follows the write commit edge, so a dependent rd is read correctly with no hazard logic.
- Undefined: instr_ready=1 only in IDLE; 4-cycle throughput.

Decomposition:
- Package rf_seq_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_AND/OP_LDI;
  - state enum;
  - instr field bit positions;
  - WIDTH/ADDR_W defaults.
- Sub-module rf_seq_alu: combinational (op, a, b, imm) -> (result, carry, zero). The FSM and register capture stay in rf_sequencer.

Test Plan:
- Bench instantiates rf_sequencer wired to reg_file.
- LDI r0,#5; LDI r1,#3; ADD r2,r0,r1 -> write_en pulses with SEL_W=2, DATA_IN=8; carry=0, zero=0; each done occurs 3 cycles after acceptance.
- LDI r0,#9; LDI r1,#9; ADD r3,r0,r1 -> Q3=2, carry=1. Then SUB r2,r0,r1 -> Q2=0, zero=1, carry=0.
- LDI r0,#2; LDI r1,#5; SUB r0,r0,r1 (rd==ra) -> Q0=13, carry=1. Then AND r1,r0,r1 -> Q1=5, carry=0.
- Hold instr_valid high with 4 instructions queued -> acceptances spaced 4 cycles apart (3 with RF_SEQ_OVERLAP_EN). A dependent ADD immediately after LDI reads the new value.
- Assert reset during WRITE of ADD r2 -> no write (Q2 unchanged), write_en=0, next cycle state IDLE, carry=zero=0, instr_ready=1.
- Offer an instruction while busy (macro undefined) -> instr_ready=0. The instruction is accepted only in IDLE, and exactly one write results per acceptance.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, instruction
// field positions, FSM states and default widths.
package rf_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned INSTR_W    = 8;
    localparam int unsigned IMM_W      = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    localparam int unsigned OP_MSB = 7;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RD_MSB = 5;
    localparam int unsigned RD_LSB = 4;
    localparam int unsigned RA_MSB = 3;
    localparam int unsigned RA_LSB = 2;
    localparam int unsigned RB_MSB = 1;
    localparam int unsigned RB_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/rf_sequencer_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND on register operands,
// LDI passes the instruction immediate through.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [IMM_W-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] ext;

    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            OP_SUB: begin
                // Zero-extended subtraction: the top bit is the unsigned borrow.
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            OP_AND: begin
                result = a & b;
            end
            OP_LDI: begin
                result = WIDTH'(imm);
            end
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle register-file sequencer: IDLE -> READ -> EXEC -> WRITE.
// Define RF_SEQ_OVERLAP_EN to accept the next instruction during WRITE.
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   SEL_A,
    output logic [ADDR_W-1:0]   SEL_B,
    output logic [ADDR_W-1:0]   SEL_W,
    output logic                write_en,
    output logic [WIDTH-1:0]    DATA_IN,
    input  logic [WIDTH-1:0]    OUT_A,
    input  logic [WIDTH-1:0]    OUT_B,
    output logic                carry,
    output logic                zero,
    output logic                busy,
    output logic                done
);

    state_t               state, state_nxt;
    logic [INSTR_W-1:0]   instr_q;
    logic [WIDTH-1:0]     op_a, op_b, result_q;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_carry, alu_zero;
    logic                 accept;

    assign accept  = instr_valid & instr_ready;
    assign DATA_IN = result_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = READ;
            READ:  state_nxt = EXEC;
            EXEC:  state_nxt = WRITE;
            WRITE: begin
`ifdef RF_SEQ_OVERLAP_EN
                state_nxt = accept ? READ : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
        endcase
    end

    always_comb begin
`ifdef RF_SEQ_OVERLAP_EN
        instr_ready = (state == IDLE) || (state == WRITE);
`else
        instr_ready = (state == IDLE);
`endif
        busy     = (state != IDLE);
        done     = (state == WRITE);
        write_en = (state == WRITE) && !reset;
    end

    // Read selects are loaded on the accept edge so they are already valid
    // throughout READ; all selects then hold until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q  <= '0;
            SEL_A    <= '0;
            SEL_B    <= '0;
            SEL_W    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result_q <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
        end else begin
            if (accept) begin
                instr_q <= instr;
                SEL_A   <= ADDR_W'(instr[RA_MSB:RA_LSB]);
                SEL_B   <= ADDR_W'(instr[RB_MSB:RB_LSB]);
            end
            if (state == READ) begin
                op_a <= OUT_A;
                op_b <= OUT_B;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                carry    <= alu_carry;
                zero     <= alu_zero;
                SEL_W    <= ADDR_W'(instr_q[RD_MSB:RD_LSB]);
            end
        end
    end

    rf_seq_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (instr_q[OP_MSB:OP_LSB]),
        .a      (op_a),
        .b      (op_b),
        .imm    (instr_q[RA_MSB:RB_LSB]),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer driving a behavioural 4-entry register
// file; expected writes are queued at issue and checked by a monitor.
`timescale 1ns/1ps
module tb_rf_sequencer;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned ADDR_W = 2;
`ifdef RF_SEQ_OVERLAP_EN
    localparam int unsigned SPACING = 3;
`else
    localparam int unsigned SPACING = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] SEL_A, SEL_B, SEL_W;
    logic              write_en;
    logic [WIDTH-1:0]  DATA_IN, OUT_A, OUT_B;
    logic              carry, zero, busy, done;

    logic [WIDTH-1:0]  rf [4] = '{default: '0};
    int unsigned       cyc = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  data;
        logic        c;
        logic        z;
        int unsigned acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rf_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .SEL_A       (SEL_A),
        .SEL_B       (SEL_B),
        .SEL_W       (SEL_W),
        .write_en    (write_en),
        .DATA_IN     (DATA_IN),
        .OUT_A       (OUT_A),
        .OUT_B       (OUT_B),
        .carry       (carry),
        .zero        (zero),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (write_en) rf[SEL_W] <= DATA_IN;
    assign OUT_A = rf[SEL_A];
    assign OUT_B = rf[SEL_B];

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Offer an instruction and wait (bounded) for the edge that accepts it.
    task automatic issue(input logic [7:0] ins, input logic [1:0] sel, input logic [3:0] data,
                         input logic c, input logic z, input bit expect_write,
                         output int unsigned acc);
        int unsigned waited = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        #1;
        while (!instr_ready) begin
            if (waited >= 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout instr=%h ready=%0d required=1", ins, instr_ready);
                instr_valid = 1'b0;
                acc = 0;
                return;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        acc = cyc + 1;
        if (expect_write) exp_q.push_back('{sel: sel, data: data, c: c, z: z, acc: acc});
    endtask

    task automatic idle();
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic run(input logic [7:0] ins, input logic [1:0] sel, input logic [3:0] data,
                       input logic c, input logic z);
        int unsigned acc;
        issue(ins, sel, data, c, z, 1'b1, acc);
        idle();
    endtask

    task automatic drain();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 60);
        if (exp_q.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%0d required 0/0", exp_q.size(), busy);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (write_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write sel=%0d data=%0d required no write", SEL_W, DATA_IN);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_sel",  SEL_W,   e.sel);
                check("wr_data", DATA_IN, e.data);
                check("carry",   carry,   e.c);
                check("zero",    zero,    e.z);
                check("done",    done,    1);
                check("latency", cyc + 1 - e.acc, 3);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a0, a1, a2, a3;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_sel_a",  SEL_A,       0);
        check("rst_sel_b",  SEL_B,       0);
        check("rst_sel_w",  SEL_W,       0);
        check("rst_data",   DATA_IN,     0);
        check("rst_wr_en",  write_en,    0);
        check("rst_flags",  {carry, zero, done, busy}, 0);
        check("rst_ready",  instr_ready, 1);

        // LDI r0,#5; LDI r1,#3; ADD r2,r0,r1; LDI r3,#0
        run(8'hC5, 2'd0, 4'd5, 1'b0, 1'b0);
        run(8'hD3, 2'd1, 4'd3, 1'b0, 1'b0);
        run(8'h21, 2'd2, 4'd8, 1'b0, 1'b0);
        run(8'hF0, 2'd3, 4'd0, 1'b0, 1'b1);
        drain();
        check("q2_add", rf[2], 8);
        check("q3_ldi0", rf[3], 0);

        // LDI r0,#9; LDI r1,#9; ADD r3 (overflow); SUB r2 (equal)
        run(8'hC9, 2'd0, 4'd9, 1'b0, 1'b0);
        run(8'hD9, 2'd1, 4'd9, 1'b0, 1'b0);
        run(8'h31, 2'd3, 4'd2, 1'b1, 1'b0);
        run(8'h61, 2'd2, 4'd0, 1'b0, 1'b1);
        drain();
        check("q3_ovf", rf[3], 2);
        check("q2_sub0", rf[2], 0);

        // LDI r0,#2; LDI r1,#5; SUB r0,r0,r1 (borrow, rd==ra); AND r1,r0,r1
        run(8'hC2, 2'd0, 4'd2,  1'b0, 1'b0);
        run(8'hD5, 2'd1, 4'd5,  1'b0, 1'b0);
        run(8'h41, 2'd0, 4'd13, 1'b1, 1'b0);
        run(8'h91, 2'd1, 4'd5,  1'b0, 1'b0);
        drain();
        check("q0_borrow", rf[0], 13);
        check("q1_and", rf[1], 5);

        // Back-to-back with valid held: LDI r3,#7; ADD r2,r3,r3; ADD r1,r2,r2; SUB r0,r3,r2
        issue(8'hF7, 2'd3, 4'd7, 1'b0, 1'b0, 1'b1, a0);
        @(negedge clk);
        #1;
        check("busy_ready", instr_ready, 0);
        check("busy_flag",  busy, 1);
        issue(8'h2F, 2'd2, 4'd14, 1'b0, 1'b0, 1'b1, a1);
        issue(8'h1A, 2'd1, 4'd12, 1'b1, 1'b0, 1'b1, a2);
        issue(8'h4E, 2'd0, 4'd9,  1'b1, 1'b0, 1'b1, a3);
        idle();
        drain();
        check("spacing_1", a1 - a0, SPACING);
        check("spacing_2", a2 - a1, SPACING);
        check("spacing_3", a3 - a2, SPACING);
        check("q0_b2b", rf[0], 9);
        check("q1_b2b", rf[1], 12);

        // ADD r2,r0,r0 abandoned by reset during its WRITE cycle
        issue(8'h20, 2'd2, 4'd2, 1'b1, 1'b0, 1'b0, a0);
        idle();
        begin
            int unsigned n = 0;
            while (!done && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("reach_write", done, 1);
        end
        reset = 1'b1;
        #1;
        check("rst_mid_wr_en", write_en, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_ready", instr_ready, 1);
        check("rst_mid_busy",  busy, 0);
        check("rst_mid_flags", {carry, zero}, 0);
        check("rst_mid_q2",    rf[2], 14);

        // Recovery: SUB r3,r3,r3
        run(8'h7F, 2'd3, 4'd0, 1'b0, 1'b1);
        drain();
        check("q3_recover", rf[3], 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
